// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract built from 4-bit carry-lookahead groups.
// The operand is split into STAGES equal segments, LSB first; each stage
// resolves one segment using the carry registered by the stage before it.
// Operand bits not yet consumed and sum bits already produced ride along
// in the stage registers, so every result leaves the last stage aligned.
// A valid/ready handshake with one valid bit per stage gives full
// throughput and lossless back-pressure.
module pipe_cla_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned GPS  = SEG / 4;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registers: valid, operand A, conditioned operand B,
    // partial sum, carry out of the segment, carry into the segment MSB.
    logic             v_q  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             cm_q [STAGES];

    // Next-state values feeding each stage register.
    logic [WIDTH-1:0] n_a  [STAGES];
    logic [WIDTH-1:0] n_b  [STAGES];
    logic [WIDTH-1:0] n_s  [STAGES];
    logic             n_c  [STAGES];
    logic             n_cm [STAGES];

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] adv;

    // 4-bit lookahead group: returns {G, P, carry into bit 3, sum[3:0]}.
    function automatic logic [6:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       ci
    );
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       gg;
        logic       pg;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & ci);
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
        pg = &p;
        return {gg, pg, c3, p ^ {c3, c2, c1, ci}};
    endfunction

    // Resolve segment k of (sa + sb + sc) on top of the partial sum ss.
    // Returns {carry into segment MSB, segment carry-out, updated sum}.
    function automatic logic [WIDTH+1:0] seg_add(
        input logic [WIDTH-1:0] sa,
        input logic [WIDTH-1:0] sb,
        input logic [WIDTH-1:0] ss,
        input logic             sc,
        input int unsigned      k
    );
        logic [WIDTH-1:0] ns;
        logic [6:0]       r;
        logic             cg;
        logic             cm;
        int unsigned      base;
        ns = ss;
        cg = sc;
        cm = 1'b0;
        for (int unsigned g = 0; g < GPS; g++) begin
            base         = k * SEG + g * 4;
            r            = cla4(sa[base +: 4], sb[base +: 4], cg);
            ns[base +: 4] = r[3:0];
            cm           = r[4];
            // Group-level lookahead: carry into the next group from G/P.
            cg           = r[6] | (r[5] & cg);
        end
        return {cm, cg, ns};
    endfunction

    // Segment arithmetic for every stage, sourced from the ports (stage 0)
    // or from the preceding stage register.
    always_comb begin : seg_calc
        logic [WIDTH+1:0] res;
        n_a[0] = a;
        n_b[0] = b ^ {WIDTH{sub}};
        res    = seg_add(a, b ^ {WIDTH{sub}}, '0, c_in ^ sub, 0);
        n_s[0]  = res[WIDTH-1:0];
        n_c[0]  = res[WIDTH];
        n_cm[0] = res[WIDTH+1];
        for (int unsigned k = 1; k < STAGES; k++) begin
            n_a[k]  = a_q[k-1];
            n_b[k]  = b_q[k-1];
            res     = seg_add(a_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], k);
            n_s[k]  = res[WIDTH-1:0];
            n_c[k]  = res[WIDTH];
            n_cm[k] = res[WIDTH+1];
        end
    end

    // Handshake chain: a stage loads when empty or when its content moves
    // on this cycle; evaluated from the output back so out_ready reaches
    // in_ready combinationally without a bubble.
    always_comb begin
        src_v    = '0;
        ld       = '0;
        adv      = '0;
        src_v[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
        end
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (LAST - i == LAST) begin
                adv[LAST - i] = v_q[LAST - i] & out_ready;
            end else begin
                adv[LAST - i] = v_q[LAST - i] & ld[LAST - i + 1];
            end
            ld[LAST - i] = ~v_q[LAST - i] | adv[LAST - i];
        end
    end

    // Stage registers: valid follows the upstream valid on load; data only
    // updates when a real operation moves in, so stalled outputs stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                cm_q[k] <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        a_q[k]  <= n_a[k];
                        b_q[k]  <= n_b[k];
                        s_q[k]  <= n_s[k];
                        c_q[k]  <= n_c[k];
                        cm_q[k] <= n_cm[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign c_out     = c_q[LAST];
    assign ovf       = c_q[LAST] ^ cm_q[LAST];

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Self-checking bench for pipe_cla_addsub (WIDTH=16, STAGES=2): directed
// scenarios plus a randomized run scored against an integer-arithmetic model.
module tb_pipe_cla_addsub;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int tests;
    int fails;

    pipe_cla_addsub #(.WIDTH(16), .STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, c_out, sum} from signed/unsigned integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
        int ux, uy, sx, sy, ures, sres;
        logic co, o;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            ures = ux + uy + int'(ci);
            sres = sx + sy + int'(ci);
            co   = (ures > 65535);
        end else begin
            ures = ux - uy - int'(ci);
            sres = sx - sy - int'(ci);
            co   = (ux >= uy + int'(ci));
        end
        o = (sres > 32767) || (sres < -32768);
        return {o, co, 16'(ures)};
    endfunction

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic s);
        in_valid = v;
        a        = x;
        b        = y;
        c_in     = ci;
        sub      = s;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #3;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if ({ovf, c_out, sum} !== 18'h0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", {ovf, c_out, sum}); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_latency1 got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency2 got=%b exp=1", out_valid); end
        tests++; if ({ovf, c_out, sum} !== {1'b0, 1'b0, 16'h0003}) begin fails++; $display("FAIL basic_result got=%h exp=00003", {ovf, c_out, sum}); end
        @(posedge clk); #1;
    endtask

    // Two operations back to back; results must appear on consecutive cycles.
    task automatic test_pair(input string name,
                             input logic [15:0] x0, input logic [15:0] y0, input logic ci0, input logic s0,
                             input logic [15:0] x1, input logic [15:0] y1, input logic ci1, input logic s1,
                             input logic [17:0] e0, input logic [17:0] e1);
        out_ready = 1'b1;
        drive(1'b1, x0, y0, ci0, s0);
        @(posedge clk); #1;
        drive(1'b1, x1, y1, ci1, s1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if ({out_valid, ovf, c_out, sum} !== {1'b1, e0}) begin fails++; $display("FAIL %s_first got=%b_%h exp=1_%h", name, out_valid, {ovf, c_out, sum}, e0); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if ({out_valid, ovf, c_out, sum} !== {1'b1, e1}) begin fails++; $display("FAIL %s_second got=%b_%h exp=1_%h", name, out_valid, {ovf, c_out, sum}, e1); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'(i), 16'h0000, 1'b0, 1'b0);
            @(negedge clk);
            tests++; if (in_ready !== (i <= 2)) begin fails++; $display("FAIL bp_in_ready_%0d got=%b exp=%b", i, in_ready, (i <= 2)); end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, 16'h0001}) begin fails++; $display("FAIL bp_hold got=%b%b_%h exp=10_0001", out_valid, in_ready, sum); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++; if ({in_ready, out_valid, sum} !== {1'b1, 1'b1, 16'h0001}) begin fails++; $display("FAIL bp_release got=%b%b_%h exp=11_0001", in_ready, out_valid, sum); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            tests++; if ({out_valid, sum} !== {1'b1, 16'(i)}) begin fails++; $display("FAIL bp_order_%0d got=%b_%h exp=1_%h", i, out_valid, sum, 16'(i)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(1'b1, 16'h0010, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 16'h0020, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_loaded got=%b exp=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({out_valid, ovf, c_out, sum} !== 19'h0) begin fails++; $display("FAIL rstmid_clear got=%h exp=0", {out_valid, ovf, c_out, sum}); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=0", i, out_valid); end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random;
        logic [17:0] q[$];
        logic [17:0] exp_r;
        logic [18:0] held;
        logic        stalled;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive(($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
                  1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled) begin
                tests++; if ({out_valid, ovf, c_out, sum} !== held) begin fails++; $display("FAIL rand_stall_hold cyc=%0d got=%h exp=%h", cyc, {out_valid, ovf, c_out, sum}, held); end
            end
            if (out_valid && out_ready) begin
                exp_r = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                tests++; if ({ovf, c_out, sum} !== exp_r) begin fails++; $display("FAIL rand_result cyc=%0d got=%h exp=%h", cyc, {ovf, c_out, sum}, exp_r); end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, c_in, sub));
            stalled = out_valid && !out_ready;
            held    = {out_valid, ovf, c_out, sum};
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_r = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
                tests++; if ({ovf, c_out, sum} !== exp_r) begin fails++; $display("FAIL rand_drain got=%h exp=%h", {ovf, c_out, sum}, exp_r); end
            end
            @(posedge clk); #1;
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rand_lost got=%0d pending exp=0", q.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_pair("carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0,
                  {1'b0, 1'b0, 16'h0100}, {1'b0, 1'b1, 16'h0000});
        test_pair("ovf_sub", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0005, 16'h0006, 1'b0, 1'b1,
                  {1'b1, 1'b0, 16'h8000}, {1'b0, 1'b0, 16'hFFFF});
        test_pair("borrow", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1,
                  {1'b0, 1'b1, 16'h0001}, {1'b1, 1'b1, 16'h7FFF});
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
